// File: rtl/btb_update_queue.sv
// Write-side producer for the direct-mapped BTB: filters resolved branches, queues them
// with tail coalescing and drains one write per cycle. Optional define: BTB_UPDATE_BYPASS_EN.
module btb_update_queue #(
    parameter  int INDEX_WIDTH = 12,
    parameter  int DEPTH       = 4,
    localparam int TW          = 30 - INDEX_WIDTH,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    input  logic                   res_is_branch_i,
    input  logic                   res_taken_i,
    input  logic [31:0]            res_pc_i,
    input  logic [31:0]            res_target_i,
    input  logic                   pred_hit_i,
    input  logic [31:0]            pred_target_i,
    input  logic                   wr_ready_i,
    output logic                   wren_o,
    output logic [INDEX_WIDTH-1:0] wr_index_o,
    output logic [TW-1:0]          wr_tag_o,
    output logic [31:0]            wr_target_o,
    output logic [CW-1:0]          count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INDEX_WIDTH-1:0] idx_mem [DEPTH];
    logic [TW-1:0]          tag_mem [DEPTH];
    logic [31:0]            tgt_mem [DEPTH];

    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [PW-1:0]          last;
    logic [CW-1:0]          count;

    logic [INDEX_WIDTH-1:0] new_index;
    logic [TW-1:0]          new_tag;
    logic                   pc_unused;

    logic q_empty;
    logic q_full;
    logic accept;
    logic need_wr;
    logic deq;
    logic coalesce;
    logic bypass;
    logic enq;

    assign new_index = res_pc_i[INDEX_WIDTH+1:2];
    assign new_tag   = res_pc_i[31:INDEX_WIDTH+2];
    assign pc_unused = ^res_pc_i[1:0];
    assign last      = tail - PW'(1);

    // Coalescing is suppressed when the single remaining entry leaves this cycle,
    // otherwise the update would land on an entry already handed to the BTB.
    always_comb begin
        q_empty     = (count == '0);
        q_full      = (count == CW'(DEPTH));
        res_ready_o = !rst_i && !q_full;
        accept      = res_valid_i && res_ready_o;
        need_wr     = accept && res_is_branch_i && res_taken_i &&
                      (!pred_hit_i || (pred_target_i != res_target_i));
        deq         = !rst_i && !q_empty && wr_ready_i;
`ifdef BTB_UPDATE_BYPASS_EN
        bypass      = need_wr && q_empty && wr_ready_i;
`else
        bypass      = 1'b0;
`endif
        coalesce    = need_wr && !q_empty && (idx_mem[last] == new_index) &&
                      !(deq && (count == CW'(1)));
        enq         = need_wr && !coalesce && !bypass;
    end

    always_comb begin
        wren_o  = deq || bypass;
        count_o = rst_i ? '0 : count;
        empty_o = rst_i || q_empty;
        full_o  = !rst_i && q_full;
`ifdef BTB_UPDATE_BYPASS_EN
        if (bypass) begin
            wr_index_o  = new_index;
            wr_tag_o    = new_tag;
            wr_target_o = res_target_i;
        end else begin
            wr_index_o  = idx_mem[head];
            wr_tag_o    = tag_mem[head];
            wr_target_o = tgt_mem[head];
        end
`else
        wr_index_o  = idx_mem[head];
        wr_tag_o    = tag_mem[head];
        wr_target_o = tgt_mem[head];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (enq) begin
                idx_mem[tail] <= new_index;
                tag_mem[tail] <= new_tag;
                tgt_mem[tail] <= res_target_i;
            end else if (coalesce) begin
                tag_mem[last] <= new_tag;
                tgt_mem[last] <= res_target_i;
            end
        end
    end

endmodule
